// File: rtl/lfsr_pkg.sv
// Shared constants and feedback helper for the 12-bit maximal-length LFSR
// (polynomial x^12+x^6+x^4+x+1).
package lfsr_pkg;

  localparam int          LFSR_WIDTH = 12;
  localparam logic [11:0] LFSR_SEED  = 12'h001;
  localparam logic [11:0] LFSR_TAPS  = 12'h829;

  typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

  // XOR of tapped bits 11, 5, 3 and 0
  function automatic logic lfsr_feedback(input lfsr_state_t state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state for the Fibonacci LFSR: left shift with feedback
// into bit 0. The all-zero lock-up state is steered back to the seed.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [11:0] state_i,
  output logic [11:0] next_o
);

  // Next-state selection with lock-up recovery
  always_comb begin
    next_o = LFSR_SEED;
    if (state_i == 12'h000) begin
      next_o = LFSR_SEED;
    end else begin
      next_o = {state_i[LFSR_WIDTH-2:0], lfsr_feedback(state_i)};
    end
  end

endmodule

// File: rtl/lfsr.sv
// 12-bit LFSR top: state register, end-of-period tick register and reset.
// rst_n is asynchronous and active-high despite its name.
module lfsr
  import lfsr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sh_en,
  output logic [11:0] Q_out,
  output logic        max_tick_reg
);

  logic [11:0] state_q;
  logic [11:0] state_d;
  logic [11:0] next_s;
  logic        tick_q;
  logic        tick_d;

  lfsr_next u_next (
    .state_i (state_q),
    .next_o  (next_s)
  );

  // Advance or hold; tick flags the step that lands back on the seed
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    if (sh_en == 1'b1) begin
      state_d = next_s;
      tick_d  = (next_s == LFSR_SEED);
    end else begin
      state_d = state_q;
      tick_d  = 1'b0;
    end
  end

  // State and tick registers with asynchronous reset to the seed
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= LFSR_SEED;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  assign Q_out        = state_q;
  assign max_tick_reg = tick_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed self-checking bench for the 12-bit LFSR: reset, sequence start,
// full period with tick, hold, asynchronous reset and lock-up recovery.
module tb_lfsr;

  logic        clk;
  logic        rst_n;
  logic        sh_en;
  logic [11:0] Q_out;
  logic        max_tick_reg;

  int n_checks = 0;
  int n_errors = 0;

  lfsr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sh_en        (sh_en),
    .Q_out        (Q_out),
    .max_tick_reg (max_tick_reg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  logic [11:0] start_seq [5];
  logic [11:0] q;
  bit          seen [4096];
  int          tick_cnt;
  int          tick_at;
  logic [11:0] q_at_tick;
  int          distinct;
  int          zero_hits;

  initial begin
    start_seq[0] = 12'h003;
    start_seq[1] = 12'h007;
    start_seq[2] = 12'h00F;
    start_seq[3] = 12'h01E;
    start_seq[4] = 12'h03D;

    rst_n = 1'b1;
    sh_en = 1'b1;
    #1;
    check_val("reset_q_immediate", Q_out, 12'h001);

    // Reset held for 10 clocks with shifting requested
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("reset_q", Q_out, 12'h001);
      check_val("reset_tick", {11'h000, max_tick_reg}, 12'h000);
    end

    // Full period after release
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    tick_cnt  = 0;
    tick_at   = 0;
    q_at_tick = 12'h000;
    distinct  = 0;
    zero_hits = 0;
    rst_n = 1'b0;
    for (int i = 1; i <= 4095; i++) begin
      @(negedge clk);
      q = Q_out;
      if (i <= 5) check_val($sformatf("start_seq_%0d", i), q, start_seq[i-1]);
      if (q == 12'h000) zero_hits++;
      if (!seen[q]) begin
        seen[q] = 1'b1;
        distinct++;
      end
      if (max_tick_reg) begin
        tick_cnt++;
        tick_at   = i;
        q_at_tick = q;
      end
    end
    check_val("period_tick_count", 12'(tick_cnt), 12'd1);
    check_val("period_tick_step", 12'(tick_at), 12'd4095);
    check_val("period_tick_q", q_at_tick, 12'h001);
    check_val("period_distinct", 12'(distinct), 12'd4095);
    check_val("period_zero_hits", 12'(zero_hits), 12'd0);

    // Seamless wrap
    @(negedge clk);
    check_val("wrap_q", Q_out, 12'h003);
    check_val("wrap_tick", {11'h000, max_tick_reg}, 12'h000);
    @(negedge clk);
    check_val("pre_hold_q1", Q_out, 12'h007);
    @(negedge clk);
    check_val("pre_hold_q2", Q_out, 12'h00F);
    @(negedge clk);
    check_val("pre_hold_q3", Q_out, 12'h01E);

    // Hold for 5 cycles then resume
    sh_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_q", Q_out, 12'h01E);
      check_val("hold_tick", {11'h000, max_tick_reg}, 12'h000);
    end
    sh_en = 1'b1;
    @(negedge clk);
    check_val("resume_q1", Q_out, 12'h03D);
    @(negedge clk);
    check_val("resume_q2", Q_out, 12'h07B);

    // Asynchronous reset between edges
    #5;
    rst_n = 1'b1;
    #1;
    check_val("async_rst_q", Q_out, 12'h001);
    check_val("async_rst_tick", {11'h000, max_tick_reg}, 12'h000);
    @(negedge clk);
    check_val("async_rst_hold_q", Q_out, 12'h001);
    check_val("async_rst_hold_tick", {11'h000, max_tick_reg}, 12'h000);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("post_rst_first", Q_out, 12'h003);

    // Lock-up recovery from a forced all-zero state
    force dut.state_q = 12'h000;
    #1;
    check_val("forced_zero", Q_out, 12'h000);
    release dut.state_q;
    @(negedge clk);
    check_val("lockup_recover_q", Q_out, 12'h001);
    check_val("lockup_recover_tick", {11'h000, max_tick_reg}, 12'h001);
    @(negedge clk);
    check_val("after_recover_q", Q_out, 12'h003);
    check_val("after_recover_tick", {11'h000, max_tick_reg}, 12'h000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
